// File: rtl/regfile_param_if.sv
// Register-file port bundle: decode read side, writeback write side,
// load scoreboard controls and the init-done flag.
interface regfile_param_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   localparam int AW = $clog2(NREG);

   logic            ready;
   logic            WE3;
   logic [AW-1:0]   A3;
   logic [XLEN-1:0] WD3;
   logic [AW-1:0]   A1;
   logic [AW-1:0]   A2;
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic            busy_set;
   logic [AW-1:0]   busy_A;
   logic            busy1;
   logic            busy2;

   modport master (
      output WE3, A3, WD3, A1, A2, busy_set, busy_A,
      input  ready, RD1, RD2, busy1, busy2
   );

   modport slave (
      input  WE3, A3, WD3, A1, A2, busy_set, busy_A,
      output ready, RD1, RD2, busy1, busy2
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised integer register file: 2 async reads, 1 sync write,
// optional bypass, sequential init engine and pending-load scoreboard.
module regfile_param #(
   parameter int              XLEN      = 32,
   parameter int              NREG      = 32,
   parameter int              ZERO_REG  = 1,
   parameter int              BYPASS    = 1,
   parameter int              INIT_IDX0 = 5,
   parameter logic [XLEN-1:0] INIT_VAL0 = XLEN'(6),
   parameter int              INIT_IDX1 = 9,
   parameter logic [XLEN-1:0] INIT_VAL1 = XLEN'(32'h2004)
) (
   input logic            clk,
   input logic            rst,
   regfile_param_if.slave rf
);
   localparam int AW = $clog2(NREG);

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t            state;
   logic [AW-1:0]     cnt;
   logic              ready;
   logic [NREG-1:0]   busy;
   logic [XLEN-1:0]   regs [NREG];

   logic              we_eff;
   logic              set_eff;
   logic              hit1;
   logic              hit2;
   logic [XLEN-1:0]   init_val;

   assign we_eff  = ready && rf.WE3 &&
                    (rf.A3 != '0 || ZERO_REG == 0);
   assign set_eff = ready && rf.busy_set &&
                    (rf.busy_A != '0 || ZERO_REG == 0);
   assign hit1    = BYPASS != 0 && we_eff && rf.A3 == rf.A1;
   assign hit2    = BYPASS != 0 && we_eff && rf.A3 == rf.A2;

   always_comb begin
      init_val = '0;
      if (cnt == AW'(INIT_IDX0))
         init_val = INIT_VAL0;
      else if (cnt == AW'(INIT_IDX1))
         init_val = INIT_VAL1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INIT;
         cnt   <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               if (cnt == AW'(NREG - 1)) begin
                  state <= S_RUN;
                  ready <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            S_RUN: begin
               state <= S_RUN;
               ready <= 1'b1;
            end
            default: begin
               state <= S_INIT;
               cnt   <= '0;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // A new issue on the same edge supersedes the returning result.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (set_eff && rf.busy_A == AW'(i))
               busy[i] <= 1'b1;
            else if (we_eff && rf.A3 == AW'(i))
               busy[i] <= 1'b0;
         end
      end
   end

   // Contents survive reset; only the init engine rewrites them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT)
            regs[cnt] <= init_val;
         else if (we_eff)
            regs[rf.A3] <= rf.WD3;
      end
   end

   always_comb begin
      rf.RD1 = '0;
      rf.RD2 = '0;
      if (ready) begin
         if (ZERO_REG != 0 && rf.A1 == '0)
            rf.RD1 = '0;
         else if (hit1)
            rf.RD1 = rf.WD3;
         else
            rf.RD1 = regs[rf.A1];
         if (ZERO_REG != 0 && rf.A2 == '0)
            rf.RD2 = '0;
         else if (hit2)
            rf.RD2 = rf.WD3;
         else
            rf.RD2 = regs[rf.A2];
      end
   end

   assign rf.busy1 = ready && busy[rf.A1] && !hit1;
   assign rf.busy2 = ready && busy[rf.A2] && !hit2;
   assign rf.ready = ready;
endmodule
